// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side consumer for the asynchronous FIFO.
//
// Pops one word whenever the FIFO is not empty and transmits it LSB-first on an
// asynchronous serial line. A frame is a start bit, DATA_WIDTH data bits, an
// optional parity bit and a stop bit. Each bit lasts CLKS_PER_BIT cycles. All
// outputs are registered.
//
// Optional feature macro: FIFO_TX_PARITY_EN
//   When defined, a parity bit is inserted after the data bits.
//   The parity bit is XOR of the word XOR PAR_TYP (0 = even, 1 = odd).
//   When undefined, PAR_TYP is ignored.
//
// Parameters:
//   DATA_WIDTH    word width; must match the FIFO's DATA_WIDTH
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   CLK      in   read-domain clock (same as the FIFO's R_CLK)
//   RST      in   synchronous active-high reset
//   EMPTY    in   FIFO empty flag
//   RD_DATA  in   FIFO read data, valid while EMPTY=0
//   PAR_TYP  in   parity type, sampled with the word
//   R_INC    out  one-cycle FIFO pop strobe per word
//   TX_OUT   out  serial line, idles high
//   BUSY     out  high while a frame is in progress
//   DONE     out  one-cycle pulse in the final cycle of the stop bit
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned TickW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be 2 or more");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef FIFO_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic                    r_inc_q, r_inc_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tick_last;
  logic                    bit_last;

`ifdef FIFO_TX_PARITY_EN
  // Parity is computed from the word and PAR_TYP at the capture edge, so later
  // changes on either input cannot disturb the frame in flight.
  logic                    par_q, par_d;
`else
  logic                    unused_par_typ;
  assign unused_par_typ = PAR_TYP;
`endif

  assign tick_last = (tick_q == TickW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BitW'(DATA_WIDTH - 1));

  // Next-state, counters and shift register.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    r_inc_d = 1'b0;
`ifdef FIFO_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!EMPTY) begin
          sr_d    = RD_DATA;
          r_inc_d = 1'b1;
          state_d = StStart;
`ifdef FIFO_TX_PARITY_EN
          par_d   = (^RD_DATA) ^ PAR_TYP;
`endif
        end
      end
      StStart: begin
        if (tick_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick_last) begin
          if (bit_last) begin
`ifdef FIFO_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            sr_d  = sr_q >> 1;
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      StParity: begin
        if (tick_last) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Both counters restart on every state change; the tick counter free-runs
    // 0..CLKS_PER_BIT-1 inside a serial state and stays at 0 in IDLE.
    if (state_d != state_q) begin
      tick_d = '0;
      bit_d  = '0;
    end else if (state_q != StIdle) begin
      if (tick_last) begin
        tick_d = '0;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Registered outputs are derived from the state being entered so that they
  // change on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = sr_d[0];
`ifdef FIFO_TX_PARITY_EN
      StParity: tx_d = par_q;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StStop) && (tick_d == TickW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      r_inc_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      r_inc_q <= r_inc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FIFO_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign R_INC  = r_inc_q;
  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = DW + 2 + P;   // bits per frame
  localparam int F  = NB * CPB;     // cycles per frame

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EMPTY = 1'b1;
  logic [DW-1:0] RD_DATA = '0;
  logic          PAR_TYP = 1'b0;
  logic          R_INC, TX_OUT, BUSY, DONE;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EMPTY  (EMPTY),
    .RD_DATA(RD_DATA),
    .PAR_TYP(PAR_TYP),
    .R_INC  (R_INC),
    .TX_OUT (TX_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Bench-side FIFO (pops one edge after R_INC is seen) and the model's copy.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];
  logic          hold = 1'b0;
  logic          pend_pop = 1'b0;

  // Reference model: a frame is just a cycle index t in 0..F-1.
  logic          m_active = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_word = '0;
  logic          m_par = 1'b0;

  // Last sample.
  logic s_rinc, s_tx, s_busy, s_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return m_word[b-1];
    if (P == 1 && b == DW + 1) return (^m_word) ^ m_par;
    return 1'b1;
  endfunction

  function automatic void update_view();
    EMPTY   = hold || (fq.size() == 0);
    RD_DATA = (fq.size() > 0) ? fq[0] : DW'($urandom);
  endfunction

  function automatic void push(input logic [DW-1:0] w);
    fq.push_back(w);
    mq.push_back(w);
    update_view();
  endfunction

  function automatic void model_edge();
    if (RST) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (!hold && mq.size() > 0) begin
        m_word   = mq.pop_front();
        m_par    = PAR_TYP;
        m_active = 1'b1;
        m_t      = 0;
      end
    end else begin
      m_t++;
      if (m_t == F) m_active = 1'b0;
    end
  endfunction

  task automatic step();
    logic [3:0]    exp;
    logic [DW-1:0] junk;
    model_edge();
    @(posedge CLK);
    #1;
    if (pend_pop && fq.size() > 0) junk = fq.pop_front();
    pend_pop = R_INC;
    update_view();
    s_rinc = R_INC;
    s_tx   = TX_OUT;
    s_busy = BUSY;
    s_done = DONE;
    exp = m_active ? {m_t == 0, exp_bit(m_t / CPB), 1'b1, m_t == F - 1} : 4'b0100;
    chk($sformatf("cycle%0d {rinc,tx,busy,done}", cyc), {s_rinc, s_tx, s_busy, s_done}, exp);
    cyc++;
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic          par;
    logic [10:0]   frame;   // transmitted bits, index 0 = start bit
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic tx_tr[F];
    int   busy_n, done_n, done_at, rinc_n, bit_bad, p1, p2, lowc;
    logic tx_all[3*F];
    logic busy_all[3*F];

`ifdef FIFO_TX_PARITY_EN
    tbl[0] = '{word: 8'h07, par: 1'b0, frame: 11'h60E};
    tbl[1] = '{word: 8'h07, par: 1'b1, frame: 11'h40E};
    tbl[2] = '{word: 8'hA5, par: 1'b0, frame: 11'h54A};
    tbl[3] = '{word: 8'hFF, par: 1'b1, frame: 11'h7FE};
`else
    tbl[0] = '{word: 8'hA5, par: 1'b0, frame: 11'h34A};
    tbl[1] = '{word: 8'h3C, par: 1'b1, frame: 11'h278};
    tbl[2] = '{word: 8'h00, par: 1'b0, frame: 11'h200};
    tbl[3] = '{word: 8'hFF, par: 1'b1, frame: 11'h3FE};
`endif

    // Reset held with data waiting: no pop, idle outputs.
    RST = 1'b1;
    push(8'h5A);
    repeat (3) step();
    chk("reset_no_pop", fq.size(), 1);
    fq.delete();
    mq.delete();
    update_view();
    RST = 1'b0;

    // Starvation.
    rinc_n = 0;
    lowc   = 0;
    repeat (100) begin
      step();
      rinc_n += s_rinc;
      lowc   += !s_tx;
    end
    chk("starve_rinc", rinc_n, 0);
    chk("starve_tx_low", lowc, 0);

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      PAR_TYP = tbl[i].par;
      push(tbl[i].word);
      step();
      chk($sformatf("tbl%0d_pop", i), s_rinc, 1);
      PAR_TYP = ~PAR_TYP;   // must not affect the frame in flight
      tx_tr[0] = s_tx;
      busy_n = s_busy;
      done_n = s_done;
      done_at = s_done ? 0 : -1;
      rinc_n = s_rinc;
      for (int t = 1; t < F; t++) begin
        step();
        tx_tr[t] = s_tx;
        busy_n += s_busy;
        done_n += s_done;
        rinc_n += s_rinc;
        if (s_done) done_at = t;
      end
      for (int k = 0; k < NB; k++) begin
        bit_bad = 0;
        for (int j = 0; j < CPB; j++) if (tx_tr[k*CPB+j] !== tbl[i].frame[k]) bit_bad++;
        chk($sformatf("tbl%0d_bit%0d_bad_cycles", i, k), bit_bad, 0);
      end
      chk($sformatf("tbl%0d_busy_cycles", i), busy_n, F);
      chk($sformatf("tbl%0d_done_count", i), done_n, 1);
      chk($sformatf("tbl%0d_done_cycle", i), done_at, F - 1);
      chk($sformatf("tbl%0d_rinc_count", i), rinc_n, 1);
      step();
      chk($sformatf("tbl%0d_gap", i), {s_tx, s_busy}, 2'b10);
    end

    // Back-to-back words.
    PAR_TYP = 1'b0;
    push(8'h3C);
    push(8'hC3);
    p1 = -1;
    p2 = -1;
    for (int t = 0; t < 3 * F; t++) begin
      step();
      tx_all[t]   = s_tx;
      busy_all[t] = s_busy;
      if (s_rinc) begin
        if (p1 < 0) p1 = t;
        else if (p2 < 0) p2 = t;
      end
    end
    chk("b2b_first_pop", p1, 0);
    chk("b2b_pop_spacing", p2 - p1, F + 1);
    if (p2 > 0) chk("b2b_gap_line", {tx_all[p2-1], busy_all[p2-1]}, 2'b10);
    else chk("b2b_second_pop_seen", 0, 1);

    // Mid-frame reset during the third data bit.
    push(8'h96);
    step();
    chk("mid_first_pop", s_rinc, 1);
    repeat (13) step();
    RST = 1'b1;
    push(8'h5B);
    step();
    chk("mid_reset_outputs", {s_tx, s_busy, s_done, s_rinc}, 4'b1000);
    RST = 1'b0;
    step();
    chk("mid_fresh_pop", s_rinc, 1);
    repeat (F + 2) step();
    chk("mid_fifo_drained", fq.size(), 0);

    // Randomized traffic, hold, parity and occasional resets against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(24, 0) == 0 && fq.size() < 4) push(DW'($urandom));
      if ($urandom_range(59, 0) == 0) begin
        hold = ~hold;
        update_view();
      end
      PAR_TYP = 1'($urandom);
      RST = ($urandom_range(399, 0) == 0);
      step();
    end
    RST  = 1'b0;
    hold = 1'b0;
    update_view();
    for (int n = 0; n < 6 * (F + 1) && (m_active || mq.size() > 0); n++) step();
    chk("rand_drained", {m_active, mq.size() > 0}, 2'b00);
    repeat (4) step();
    chk("rand_fifo_empty", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
